alu_mult_sequencer: RTL and testbench

- Multi-cycle signed multiply controller that time-shares the existing 32-bit combinational ALU (add/sub/bitwise datapath) to run radix-2 Booth multiplication.
- The controller drives the ALU operand and opcode inputs and holds the accumulator, multiplier, Booth bit and iteration counter.
- It sits beside the ALU in the execute stage and serves mul instructions.
- Handshake: start pulse in, one-cycle ready pulse out, with an overflow exception flag.

---
 rtl/alu_mult_sequencer.sv | 133 +++++++++++++
 tb/tb_alu_mult_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mult_sequencer.sv
// Radix-2 Booth multiply sequencer that time-shares an external 32-bit
// combinational add/sub ALU. The controller owns the accumulator, the
// multiplier shift register, the Booth history bit and the iteration
// counter. It presents ALU operands only while iterating, so the ALU is
// free for other users the rest of the time.
module alu_mult_sequencer #(
    parameter int         WIDTH  = 32,
    parameter logic [4:0] OP_ADD = 5'b00000,
    parameter logic [4:0] OP_SUB = 5'b00001
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_mult,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [4:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_inA,
    output logic [WIDTH-1:0] alu_inB,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        counter;
    logic signed [WIDTH-1:0] acc;
    logic signed [WIDTH-1:0] qreg;
    logic signed [WIDTH-1:0] mreg;
    logic                    q_1;

    // The ALU result can overflow when M is the most negative value; the
    // true sign of the WIDTH+1-bit sum is the result MSB corrected by the
    // overflow flag, and it becomes the bit shifted into the accumulator.
    logic true_sign;
    assign true_sign = alu_result[WIDTH-1] ^ alu_overflow;

    // Drive the shared ALU from the Booth pair while iterating; park it at
    // add 0+0 otherwise.
    always_comb begin
        alu_opcode = OP_ADD;
        alu_inA    = '0;
        alu_inB    = '0;
        if (state == RUN) begin
            alu_inA = acc;
            case ({qreg[0], q_1})
                2'b01: begin
                    alu_opcode = OP_ADD;
                    alu_inB    = mreg;
                end
                2'b10: begin
                    alu_opcode = OP_SUB;
                    alu_inB    = mreg;
                end
                default: begin
                    alu_opcode = OP_ADD;
                    alu_inB    = '0;
                end
            endcase
        end
    end

    // Sequencer FSM: load on start (from any state), shift through WIDTH
    // Booth steps, then publish the product low half and the fit check.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            counter        <= '0;
            acc            <= '0;
            qreg           <= '0;
            mreg           <= '0;
            q_1            <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_mult) begin
                // A start always wins, aborting whatever was in flight; the
                // previous result stays visible until the new one lands.
                state   <= RUN;
                mreg    <= data_operandA;
                qreg    <= data_operandB;
                acc     <= '0;
                q_1     <= 1'b0;
                counter <= '0;
                busy    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    RUN: begin
                        // Arithmetic right shift of {sign, result, Q, q_1}.
                        acc     <= {true_sign, alu_result[WIDTH-1:1]};
                        qreg    <= {alu_result[0], qreg[WIDTH-1:1]};
                        q_1     <= qreg[0];
                        counter <= counter + 1'b1;
                        if (counter == LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end
                    end
                    DONE: begin
                        // The product fits only if the high half is pure
                        // sign extension of the low half.
                        data_resultRDY <= 1'b1;
                        data_result    <= qreg;
                        data_exception <= (acc != {WIDTH{qreg[WIDTH-1]}});
                        state          <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Bench for alu_mult_sequencer: models the external add/sub ALU, keeps a
// behavioural reference (64-bit product plus start/abort timing) and checks
// the DUT against it every cycle, plus directed literal cases.
module tb_alu_mult_sequencer;

    localparam int         W      = 32;
    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;

    logic         clock = 1'b0;
    logic         reset;
    logic         ctrl_mult;
    logic [W-1:0] a, b;
    logic [4:0]   alu_opcode;
    logic [W-1:0] alu_inA, alu_inB, alu_result;
    logic         alu_overflow;
    logic [W-1:0] data_result;
    logic         data_exception, data_resultRDY, busy;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clock = ~clock;

    alu_mult_sequencer #(.WIDTH(W), .OP_ADD(OP_ADD), .OP_SUB(OP_SUB)) dut (
        .clock(clock), .reset(reset), .ctrl_mult(ctrl_mult),
        .data_operandA(a), .data_operandB(b),
        .alu_opcode(alu_opcode), .alu_inA(alu_inA), .alu_inB(alu_inB),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .data_result(data_result), .data_exception(data_exception),
        .data_resultRDY(data_resultRDY), .busy(busy)
    );

    // External ALU: signed add/sub with overflow flag.
    always_comb begin
        if (alu_opcode == OP_SUB) begin
            alu_result   = alu_inA - alu_inB;
            alu_overflow = (alu_inA[W-1] != alu_inB[W-1]) && (alu_result[W-1] != alu_inA[W-1]);
        end else begin
            alu_result   = alu_inA + alu_inB;
            alu_overflow = (alu_inA[W-1] == alu_inB[W-1]) && (alu_result[W-1] != alu_inA[W-1]);
        end
    end

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference product: {exception, low word}.
    function automatic logic [W:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        longint p;
        logic [W-1:0] lo;
        p  = longint'($signed(x)) * longint'($signed(y));
        lo = p[W-1:0];
        return {(p != longint'($signed(lo))), lo};
    endfunction

    // Timing reference: busy for 32 cycles after the start edge, result
    // pulse after 33 edges, any start restarts, reset clears everything.
    logic [W-1:0] m_a, m_b, e_res;
    int           m_age;
    bit           m_active, e_busy, e_rdy, e_exc;

    always @(posedge clock) begin
        if (reset) begin
            m_active = 1'b0; e_busy = 1'b0; e_rdy = 1'b0; e_res = '0; e_exc = 1'b0;
        end else if (ctrl_mult) begin
            m_a = a; m_b = b; m_active = 1'b1; m_age = 0; e_busy = 1'b1; e_rdy = 1'b0;
        end else begin
            e_rdy = 1'b0;
            if (m_active) begin
                m_age++;
                e_busy = (m_age < 32);
                if (m_age == 33) begin
                    {e_exc, e_res} = ref_mul(m_a, m_b);
                    e_rdy    = 1'b1;
                    m_active = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison against the reference.
    always @(negedge clock) begin
        if (chk_en) begin
            check("busy", busy, e_busy);
            check("rdy", data_resultRDY, e_rdy);
            check("result", data_result, e_res);
            check("exception", data_exception, e_exc);
            if (!e_busy) begin
                check("idle_opcode", alu_opcode, OP_ADD);
                check("idle_inA", alu_inA, 0);
                check("idle_inB", alu_inB, 0);
            end else begin
                checks++;
                if (!((alu_opcode == OP_ADD && (alu_inB == 0 || alu_inB == m_a)) ||
                      (alu_opcode == OP_SUB && alu_inB == m_a))) begin
                    failures++;
                    $display("FAIL run_alu_drive actual=op%0h/%0h expected=M %0h or 0", alu_opcode, alu_inB, m_a);
                end
            end
        end
    end

    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clock);
        ctrl_mult = 1'b1; a = x; b = y;
        @(negedge clock);
        ctrl_mult = 1'b0;
    endtask

    task automatic wait_rdy(output int edges, output int bc);
        edges = 0;
        bc    = busy ? 1 : 0;
        do begin
            @(negedge clock);
            edges++;
            if (busy) bc++;
        end while (!data_resultRDY && edges < 40);
    endtask

    task automatic run_dir(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] res, input bit exc, input string nm);
        int edges, bc;
        start_op(x, y);
        wait_rdy(edges, bc);
        check({nm, "_latency"}, edges, 33);
        check({nm, "_busycycles"}, bc, 32);
        check({nm, "_result"}, data_result, res);
        check({nm, "_exc"}, data_exception, exc);
        @(negedge clock);
        check({nm, "_rdy_single"}, data_resultRDY, 0);
        check({nm, "_hold"}, data_result, res);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'h8000_0000;
            2: return 32'h7FFF_FFFF;
            3: return W'($signed($urandom_range(0, 200)) - 100);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int edges, bc;
        logic [W-1:0] x, y;
        reset = 1'b1; ctrl_mult = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clock);
        chk_en = 1'b1;
        check("reset_result", data_result, 0);
        check("reset_busy", busy, 0);
        check("reset_rdy", data_resultRDY, 0);
        reset = 1'b0;

        // Pin the reference model itself.
        check("model_3x4", ref_mul(32'd3, 32'd4), {1'b0, 32'd12});
        check("model_min_x_m1", ref_mul(32'h8000_0000, 32'hFFFF_FFFF), {1'b1, 32'h8000_0000});

        run_dir(32'd3, 32'd4, 32'd12, 1'b0, "3x4");
        run_dir(32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 1'b0, "m7x6");
        run_dir(32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd25, 1'b0, "m5xm5");
        run_dir(32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, "2p16sq");
        run_dir(32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1, "maxx2");
        run_dir(32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, "minx1");
        run_dir(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "minxm1");
        run_dir(32'd0, 32'h8000_0000, 32'h0, 1'b0, "zero");

        // Restart during RUN.
        start_op(32'd3, 32'd4);
        repeat (9) @(negedge clock);
        start_op(32'd5, 32'd6);
        wait_rdy(edges, bc);
        check("abort_run_latency", edges, 33);
        check("abort_run_result", data_result, 32'd30);

        // Restart landing in DONE suppresses the first pulse.
        start_op(32'd7, 32'd7);
        repeat (31) @(negedge clock);
        start_op(32'd11, 32'd3);
        wait_rdy(edges, bc);
        check("abort_done_latency", edges, 33);
        check("abort_done_result", data_result, 32'd33);

        // Reset mid-operation.
        start_op(32'd9, 32'd9);
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_busy", busy, 0);
        check("midreset_rdy", data_resultRDY, 0);
        check("midreset_result", data_result, 0);
        check("midreset_exc", data_exception, 0);
        check("midreset_inA", alu_inA, 0);
        reset = 1'b0;
        run_dir(32'd2, 32'd8, 32'd16, 1'b0, "2x8");

        // Randomized operands, gaps and aborts.
        for (int i = 0; i < 40; i++) begin
            x = pick();
            y = pick();
            repeat ($urandom_range(0, 3)) @(negedge clock);
            start_op(x, y);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 34)) @(negedge clock);
            end else begin
                wait_rdy(edges, bc);
                check("rand_latency", edges, 33);
                check("rand_product", {data_exception, data_result}, ref_mul(x, y));
            end
        end
        repeat (40) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
